// File: rtl/seg7_frame_ctrl.sv
// seg7_frame_ctrl: 7-seg display source; host writes are shadowed and committed at a Scan 7->0 frame boundary. Optional readback via SEG7_FRAME_CTRL_RDBK_EN.
// Latency: all display outputs registered; an accepted write reaches them at the next frame boundary (1..8*SCAN_TICK cycles).
// Backpressure: wr_ready is low for a register whose shadow still awaits commit; reserved selects are always accepted and dropped.
module seg7_frame_ctrl #(
    parameter int SCAN_TICK    = 50000,
    parameter int FLASH_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_sel,
    input  logic [31:0] wr_data,
    output logic [31:0] Hexs,
    output logic [7:0]  LES,
    output logic [7:0]  point,
    output logic        SW0,
    output logic [2:0]  Scan,
    output logic        flash,
    output logic        frame_done
`ifdef SEG7_FRAME_CTRL_RDBK_EN
    ,
    output logic [31:0] rd_data
`endif
);

    typedef struct packed {
        logic       sw0;
        logic [7:0] point;
        logic [7:0] les;
    } attr_t;

    localparam int PW = (SCAN_TICK > 1) ? $clog2(SCAN_TICK) : 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_TICK - 1);
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);

    logic [PW-1:0] presc;
    logic [FW-1:0] frame_cnt;
    logic [31:0]   hex_shd;
    attr_t         attr_shd;
    attr_t         attr_act;
    logic [1:0]    dirty;
    logic          scan_step;
    logic          boundary;
    logic          wr_fire;
    logic [1:0]    wr_hit;

    assign scan_step = (presc == PRESC_LAST);
    assign boundary  = scan_step && (Scan == 3'd7);

    // A register can take a new value only once its pending one has been committed.
    assign wr_ready = wr_sel[1] | ~dirty[wr_sel[0]];
    assign wr_fire  = wr_valid & wr_ready;
    assign wr_hit   = {wr_fire && (wr_sel == 2'd1), wr_fire && (wr_sel == 2'd0)};

    assign LES   = attr_act.les;
    assign point = attr_act.point;
    assign SW0   = attr_act.sw0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc      <= '0;
            Scan       <= '0;
            frame_done <= 1'b0;
            frame_cnt  <= '0;
            flash      <= 1'b0;
        end else begin
            frame_done <= boundary;
            if (scan_step) begin
                presc <= '0;
                Scan  <= Scan + 3'd1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (boundary) begin
                if (frame_cnt == FRAME_LAST) begin
                    frame_cnt <= '0;
                    flash     <= ~flash;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // A write landing on the boundary edge sees dirty=0, so it is shadowed and waits a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hex_shd  <= '0;
            attr_shd <= '0;
            Hexs     <= '0;
            attr_act <= '0;
            dirty    <= '0;
        end else begin
            if (boundary && dirty[0]) Hexs     <= hex_shd;
            if (boundary && dirty[1]) attr_act <= attr_shd;
            if (wr_hit[0]) hex_shd  <= wr_data;
            if (wr_hit[1]) attr_shd <= attr_t'(wr_data[16:0]);
            dirty <= wr_hit | (dirty & {2{~boundary}});
        end
    end

`ifdef SEG7_FRAME_CTRL_RDBK_EN
    always_comb begin
        rd_data = '0;
        case (wr_sel)
            2'd0:    rd_data = Hexs;
            2'd1:    rd_data = {15'b0, attr_act};
            2'd2:    rd_data = {30'b0, dirty};
            default: rd_data = '0;
        endcase
    end
`endif

endmodule

// File: tb/tb_seg7_frame_ctrl.sv
// Bench for seg7_frame_ctrl: directed frame-commit scenarios plus random traffic against a time-based reference model.
module tb_seg7_frame_ctrl;
    localparam int SCAN_TICK    = 4;
    localparam int FLASH_FRAMES = 2;
    localparam int FRAME        = 8 * SCAN_TICK;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [1:0]  wr_sel = 2'd0;
    logic [31:0] wr_data = 32'd0;
    logic        wr_ready;
    logic [31:0] Hexs;
    logic [7:0]  LES;
    logic [7:0]  point;
    logic        SW0;
    logic [2:0]  Scan;
    logic        flash;
    logic        frame_done;
`ifdef SEG7_FRAME_CTRL_RDBK_EN
    logic [31:0] rd_data;
`endif

    seg7_frame_ctrl #(.SCAN_TICK(SCAN_TICK), .FLASH_FRAMES(FLASH_FRAMES)) dut (
        .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_sel(wr_sel), .wr_data(wr_data), .Hexs(Hexs), .LES(LES), .point(point),
        .SW0(SW0), .Scan(Scan), .flash(flash), .frame_done(frame_done)
`ifdef SEG7_FRAME_CTRL_RDBK_EN
        , .rd_data(rd_data)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: edges since reset release; a write accepted on edge e commits on edge (e/FRAME+1)*FRAME.
    int          edge_n;
    logic [31:0] act [2];
    logic [31:0] shd [2];
    logic        pend [2];
    int          due [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        edge_n = 0;
        for (int i = 0; i < 2; i++) begin
            act[i] = '0; shd[i] = '0; pend[i] = 1'b0; due[i] = 0;
        end
    endtask

    task automatic check_outputs();
        check_val("Scan", 32'(Scan), 32'((edge_n / SCAN_TICK) % 8));
        check_val("frame_done", 32'(frame_done), 32'((edge_n > 0) && (edge_n % FRAME == 0)));
        check_val("flash", 32'(flash), 32'(((edge_n / FRAME) / FLASH_FRAMES) % 2));
        check_val("Hexs", Hexs, act[0]);
        check_val("LES", 32'(LES), 32'(act[1][7:0]));
        check_val("point", 32'(point), 32'(act[1][15:8]));
        check_val("SW0", 32'(SW0), 32'(act[1][16]));
    endtask

    // One clock: drive at negedge, check wr_ready, step model at posedge, check outputs at next negedge.
    task automatic cyc(input logic v, input logic [1:0] s, input logic [31:0] d, output logic fired);
        logic rdy;
        wr_valid = v; wr_sel = s; wr_data = d;
        #1;
        rdy = s[1] || !pend[s[0]];
        check_val("wr_ready", 32'(wr_ready), 32'(rdy));
`ifdef SEG7_FRAME_CTRL_RDBK_EN
        case (s)
            2'd0:    check_val("rd_data", rd_data, act[0]);
            2'd1:    check_val("rd_data", rd_data, act[1]);
            2'd2:    check_val("rd_data", rd_data, {30'b0, pend[1], pend[0]});
            default: check_val("rd_data", rd_data, 32'd0);
        endcase
`endif
        fired = v && rdy;
        @(posedge clk);
        edge_n++;
        for (int i = 0; i < 2; i++) begin
            if (pend[i] && due[i] == edge_n) begin
                act[i] = shd[i];
                pend[i] = 1'b0;
            end
        end
        if (fired && !s[1]) begin
            pend[s[0]] = 1'b1;
            shd[s[0]]  = s[0] ? {15'b0, d[16:0]} : d;
            due[s[0]]  = (edge_n / FRAME + 1) * FRAME;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_to(input int phase);
        logic f;
        cyc(1'b0, 2'd0, 32'd0, f);
        for (int k = 0; k < FRAME && (edge_n % FRAME) != phase; k++) cyc(1'b0, 2'd0, 32'd0, f);
    endtask

    task automatic check_zero(input string tag);
        check_val({tag, "_Hexs"}, Hexs, 32'd0);
        check_val({tag, "_attr"}, {15'b0, SW0, point, LES}, 32'd0);
        check_val({tag, "_Scan"}, 32'(Scan), 32'd0);
        check_val({tag, "_flash"}, 32'(flash), 32'd0);
        check_val({tag, "_frame_done"}, 32'(frame_done), 32'd0);
        check_val({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        logic f;
        logic done;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        // Scan steps and first frame_done at edge 32.
        repeat (FRAME + 1) cyc(1'b0, 2'd0, 32'd0, f);

        // Single Hexs write mid-frame.
        idle_to(10);
        cyc(1'b1, 2'd0, 32'h1234ABCD, f);
        idle_to(FRAME - 1);
        check_val("t2_hold", Hexs, 32'd0);
        idle_to(0);
        check_val("t2_commit", Hexs, 32'h1234ABCD);

        // Hexs and attr in one frame commit together.
        idle_to(5);
        cyc(1'b1, 2'd0, 32'hCAFE0001, f);
        cyc(1'b1, 2'd1, 32'hFFF180FF, f);
        idle_to(FRAME - 1);
        check_val("t3_hold_les", 32'(LES), 32'd0);
        idle_to(0);
        check_val("t3_hexs", Hexs, 32'hCAFE0001);
        check_val("t3_les", 32'(LES), 32'hFF);
        check_val("t3_point", 32'(point), 32'h80);
        check_val("t3_sw0", 32'(SW0), 32'd1);

        // Second write while dirty stalls until the boundary clears it.
        idle_to(8);
        cyc(1'b1, 2'd0, 32'hAAAA5555, f);
        done = 1'b0;
        for (int k = 0; k < 2 * FRAME && !done; k++) begin
            cyc(1'b1, 2'd0, 32'h0BADF00D, f);
            if (f) begin
                done = 1'b1;
                check_val("t4_accept_phase", 32'(edge_n % FRAME), 32'd1);
            end
        end
        check_val("t4_accepted", 32'(done), 32'd1);
        idle_to(0);
        check_val("t4_commit", Hexs, 32'h0BADF00D);

        // Write on the boundary edge defers a full frame.
        idle_to(FRAME - 1);
        cyc(1'b1, 2'd0, 32'h5EEDC0DE, f);
        repeat (FRAME - 1) cyc(1'b0, 2'd0, 32'd0, f);
        check_val("t5_deferred", Hexs, 32'h0BADF00D);
        cyc(1'b0, 2'd0, 32'd0, f);
        check_val("t5_commit", Hexs, 32'h5EEDC0DE);

        // Random traffic across several flash periods.
        for (int k = 0; k < 8 * FRAME; k++)
            cyc(($urandom_range(2) == 0), 2'($urandom_range(3)), $urandom, f);

        // Asynchronous reset mid-frame.
        idle_to(13);
        #2 rst_n = 1'b0;
        #1 check_zero("midrst");
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        for (int k = 0; k < 2 * FRAME; k++)
            cyc(($urandom_range(2) == 0), 2'($urandom_range(3)), $urandom, f);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
